// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-way round-robin arbiter in front of the single shared
// cbus port. One transaction is granted at a time and the grant is held until
// the final (ready && last) beat; the response is steered only to the owner.
//
// Flattened bus layout (requester i occupies slice [i*W +: W]):
//   request  (REQ_W = 79):  [78] valid, [77] is_write, [76:74] size,
//                           [73:42] addr, [41:38] strobe, [37:6] data,
//                           [5:2] len, [1:0] burst
//   response (RESP_W = 34): [33] ready, [32] last, [31:0] data
module cbus_rr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int REQ_W  = 79,
    parameter int RESP_W = 34
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ*REQ_W-1:0]    ireqs,
    output logic [N_REQ*RESP_W-1:0]   iresps,
    output logic [REQ_W-1:0]          oreq,
    input  logic [RESP_W-1:0]         oresp,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [N_REQ*32-1:0]       grant_cnt
);

    localparam int REQ_VALID_BIT  = REQ_W - 1;
    localparam int RESP_READY_BIT = RESP_W - 1;
    localparam int RESP_LAST_BIT  = RESP_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]   chosen_idx;
    logic               any_valid;
    logic               complete;

    logic [N_REQ-1:0]   req_valid;
    logic [REQ_W-1:0]   req_arr [N_REQ];

    // Valid bits rotated so that bit 0 is the requester at ptr.
    logic [2*N_REQ-1:0] rot_wide;
    logic [N_REQ-1:0]   rot_valid;
    logic [N_REQ:0]     seen_chain;
    logic [IDX_W-1:0]   off_chain [N_REQ+1];
    logic [IDX_W:0]     chosen_sum;

    // Unpack the flattened request bus into per-requester words.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_arr[gi]   = ireqs[gi*REQ_W +: REQ_W];
        assign req_valid[gi] = ireqs[gi*REQ_W + REQ_VALID_BIT];
    end

    // Round-robin search: rotate by ptr, pick the first set bit, rotate back.
    assign rot_wide  = {req_valid, req_valid} >> ptr_reg;
    assign rot_valid = rot_wide[N_REQ-1:0];

    assign seen_chain[0] = 1'b0;
    assign off_chain[0]  = '0;
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_prio
        assign seen_chain[gi+1] = seen_chain[gi] | rot_valid[gi];
        assign off_chain[gi+1]  = off_chain[gi] |
                                  ((rot_valid[gi] && !seen_chain[gi]) ? IDX_W'(gi) : '0);
    end

    assign any_valid  = seen_chain[N_REQ];
    assign chosen_sum = {1'b0, ptr_reg} + {1'b0, off_chain[N_REQ]};
    assign chosen_idx = (chosen_sum >= (IDX_W+1)'(N_REQ))
                        ? IDX_W'(chosen_sum - (IDX_W+1)'(N_REQ))
                        : IDX_W'(chosen_sum);

    assign busy     = (state_reg == BUSY);
    assign complete = busy && oresp[RESP_READY_BIT] && oresp[RESP_LAST_BIT];

    // State, pointer and grant registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_idx_reg <= grant_idx_next;
        end
    end

    // Next-state: grant from IDLE, release on the final beat and advance ptr.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_idx_next = grant_idx_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    grant_idx_next = chosen_idx;
                    state_next     = BUSY;
                end
            end
            BUSY: begin
                if (complete) begin
                    state_next = IDLE;
                    ptr_next   = (grant_idx_reg == IDX_W'(N_REQ - 1))
                                 ? '0 : grant_idx_reg + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_idx = grant_idx_reg;

    // Pass the owner's request through while busy; drive zero otherwise.
    always_comb begin
        oreq = '0;
        if (busy) begin
            oreq = req_arr[grant_idx_reg];
        end
    end

    // Response steering and per-requester saturating completion counters.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
        logic [31:0] cnt_reg;
        logic        owner;

        assign owner = busy && (grant_idx_reg == IDX_W'(gi));
        assign iresps[gi*RESP_W +: RESP_W] = owner ? oresp : '0;
        assign grant_cnt[gi*32 +: 32]      = cnt_reg;

        // Count completed transactions, holding at the all-ones value.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (complete && owner && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: a two-requester instance driven by requester and
// memory models with a scoreboard monitor, plus a three-requester instance
// exercised directly for pointer wrap-around.
module tb_cbus_rr_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-requester instance
    logic [2*79-1:0] ireqs2;
    logic [2*34-1:0] iresps2;
    logic [78:0]     oreq2;
    logic [33:0]     oresp2;
    logic            busy2;
    logic [0:0]      gidx2;
    logic [63:0]     gcnt2;

    // Three-requester instance
    logic [3*79-1:0] ireqs3;
    logic [3*34-1:0] iresps3;
    logic [78:0]     oreq3;
    logic [33:0]     oresp3;
    logic            busy3;
    logic [1:0]      gidx3;
    logic [95:0]     gcnt3;

    cbus_rr_arbiter #(.N_REQ(2)) dut2 (
        .clk(clk), .reset(reset), .ireqs(ireqs2), .iresps(iresps2),
        .oreq(oreq2), .oresp(oresp2), .busy(busy2), .grant_idx(gidx2),
        .grant_cnt(gcnt2)
    );

    cbus_rr_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3),
        .oreq(oreq3), .oresp(oresp3), .busy(busy3), .grant_idx(gidx3),
        .grant_cnt(gcnt3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [78:0] pack_req(input logic v, input logic [31:0] a,
                                             input logic [3:0] l);
        return {v, 1'b0, 3'd2, a, 4'hF, 32'h0, l, (l != 4'd0) ? 2'b01 : 2'b00};
    endfunction

    // Memory data model: beat b of a burst at address a returns (a ^ K) + b.
    function automatic logic [31:0] mem_data(input logic [31:0] a, input int b);
        return (a ^ 32'h8000_1234) + 32'(b);
    endfunction

    // ---------------- requester model (dut2) ----------------
    int          want  [2] = '{0, 0};
    int          done  [2] = '{0, 0};
    int          start [2] = '{0, 0};
    logic [31:0] base  [2] = '{32'h0, 32'h0};
    logic [3:0]  blen  [2] = '{4'd0, 4'd0};

    initial begin : req_driver
        logic fin [2];
        ireqs2 = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                fin[i] = reset && iresps2[i*34+33] && iresps2[i*34+32];
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (fin[i]) done[i]++;
                ireqs2[i*79 +: 79] = pack_req(done[i] < want[i],
                                              base[i] + 32'((done[i] - start[i]) * 16),
                                              blen[i]);
            end
        end
    end

    // ---------------- memory model (dut2) ----------------
    int mem_lat = 1;

    initial begin : mem_model
        bit          m_active = 0;
        bit          m_drv    = 0;
        int          m_wait   = 0;
        int          m_beat   = 0;
        int          m_len    = 0;
        logic [31:0] m_addr   = 0;
        oresp2 = '0;
        forever begin
            @(posedge clk); #1;
            if (m_drv) begin
                if (m_beat == m_len) m_active = 0;
                m_beat++;
            end
            m_drv  = 0;
            oresp2 = '0;
            if (!reset) begin
                m_active = 0;
            end else begin
                if (!m_active && busy2 && oreq2[78]) begin
                    m_active = 1;
                    m_wait   = mem_lat;
                    m_beat   = 0;
                    m_len    = int'(oreq2[5:2]);
                    m_addr   = oreq2[73:42];
                end
                if (m_active) begin
                    if (m_wait > 0) begin
                        m_wait--;
                    end else begin
                        m_drv  = 1;
                        oresp2 = {1'b1, (m_beat == m_len), mem_data(m_addr, m_beat)};
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor (dut2) ----------------
    typedef struct {
        int          idx;
        logic [31:0] addr;
        int          len;
        int          gap;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input int idx, input logic [31:0] a, input int len,
                            input int gap, input logic [31:0] d);
        exp_t e;
        e.idx = idx; e.addr = a; e.len = len; e.gap = gap; e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        bit prev_busy = 0;
        int beats     = 0;
        int last_done = -1000;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 0;
                beats     = 0;
                continue;
            end
            for (int j = 0; j < 2; j++)
                if (!(busy2 && int'(gidx2) == j))
                    chk($sformatf("resp_leak%0d", j), 96'(iresps2[j*34 +: 34]), 96'h0);
            if (busy2 && !prev_busy) begin
                beats = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 96'(gidx2), 96'hF);
                end else begin
                    chk("grant_idx", 96'(gidx2), 96'(exp_q[0].idx));
                    if (exp_q[0].gap >= 0)
                        chk("grant_gap", 96'(cyc - last_done), 96'(exp_q[0].gap));
                end
            end
            if (busy2 && oresp2[33] && exp_q.size() > 0) begin
                beats++;
                chk("oreq_addr", 96'(oreq2[73:42]), 96'(exp_q[0].addr));
                chk("resp_route", 96'(iresps2[int'(gidx2)*34 +: 34]), 96'(oresp2));
                if (oresp2[32]) begin
                    chk("beat_count", 96'(beats), 96'(exp_q[0].len + 1));
                    chk("final_data", 96'(iresps2[int'(gidx2)*34 +: 32]), 96'(exp_q[0].data));
                    $display("[TB] txn req=%0d addr=0x%08h beats=%0d data=0x%08h cyc=%0d",
                             gidx2, oreq2[73:42], beats, iresps2[int'(gidx2)*34 +: 32], cyc);
                    void'(exp_q.pop_front());
                    last_done = cyc;
                end
            end
            prev_busy = busy2;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && done[0] == want[0] && done[1] == want[1])) begin
            @(negedge clk);
            k++;
        end
        chk("timeout", 96'(k >= budget), 96'h0);
        @(posedge clk); #3;
    endtask

    task automatic wait_beats(input int nb);
        int seen = 0;
        int k    = 0;
        while (seen < nb && k < 100) begin
            @(negedge clk);
            if (busy2 && oresp2[33]) seen++;
            k++;
        end
        chk("beat_timeout", 96'(seen), 96'(nb));
    endtask

    task automatic wait_busy3(input string name, input logic [1:0] expidx);
        int k = 0;
        @(negedge clk);
        while (!busy3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_busy"}, 96'(busy3), 96'h1);
        chk(name, 96'(gidx3), 96'(expidx));
    endtask

    task automatic finish3(input int slot);
        #1 oresp3 = {1'b1, 1'b1, 32'hCAFE_0000};
        @(posedge clk); #1;
        oresp3 = '0;
        ireqs3[slot*79 +: 79] = '0;
    endtask

    task automatic configure(input int i, input logic [31:0] b, input logic [3:0] l, input int n);
        base[i]  = b;
        blen[i]  = l;
        start[i] = done[i];
        want[i]  = done[i] + n;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        reset  = 1'b0;
        ireqs3 = '0;
        oresp3 = '0;

        // Reset held with requester 0 valid: nothing granted.
        configure(0, 32'h0000_0100, 4'd0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oreq_valid", 96'(oreq2[78]), 96'h0);
        chk("rst_busy",       96'(busy2),     96'h0);
        chk("rst_grant_idx",  96'(gidx2),     96'h0);
        chk("rst_grant_cnt",  96'(gcnt2),     96'h0);
        chk("rst_iresps",     96'(iresps2),   96'h0);
        push_exp(0, 32'h0000_0100, 0, -1, 32'h8000_1334);
        @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_t0_valid",   96'(oreq2[78]), 96'h0);
        @(negedge clk);
        chk("rel_t1_valid",   96'(oreq2[78]), 96'h1);
        wait_done(50);

        // Single read from requester 1 with a 3-cycle memory latency.
        mem_lat = 3;
        push_exp(1, 32'h8000_0000, 0, -1, 32'h0000_1234);
        configure(1, 32'h8000_0000, 4'd0, 1);
        wait_done(50);
        chk("single_cnt", 96'(gcnt2), 96'h0000_0001_0000_0001);

        // Contention from reset release: strict alternation, 5 + 5 completions.
        reset   = 1'b0;
        mem_lat = 0;
        #1;
        for (int k = 0; k < 5; k++) begin
            push_exp(0, 32'h1000 + 32'(16*k), 0, (k == 0) ? -1 : 2, mem_data(32'h1000 + 32'(16*k), 0));
            push_exp(1, 32'h2000 + 32'(16*k), 0, 2, mem_data(32'h2000 + 32'(16*k), 0));
        end
        configure(0, 32'h1000, 4'd0, 5);
        configure(1, 32'h2000, 4'd0, 5);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        wait_done(200);
        chk("contention_cnt", 96'(gcnt2), 96'h0000_0005_0000_0005);

        // Burst hold: requester 1 arrives mid-burst and waits for release.
        mem_lat = 1;
        push_exp(0, 32'h3000, 3, -1, mem_data(32'h3000, 3));
        push_exp(1, 32'h4000, 0, 2, mem_data(32'h4000, 0));
        configure(0, 32'h3000, 4'd3, 1);
        wait_beats(2);
        configure(1, 32'h4000, 4'd0, 1);
        wait_done(100);
        chk("burst_cnt", 96'(gcnt2), 96'h0000_0006_0000_0006);

        // Move the pointer to 1, then abort a requester-1 burst with reset.
        mem_lat = 0;
        push_exp(0, 32'h5000, 0, -1, mem_data(32'h5000, 0));
        configure(0, 32'h5000, 4'd0, 1);
        wait_done(50);
        push_exp(1, 32'h5100, 3, -1, mem_data(32'h5100, 3));
        configure(1, 32'h5100, 4'd3, 1);
        wait_beats(2);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy",   96'(busy2),     96'h0);
        chk("abort_valid",  96'(oreq2[78]), 96'h0);
        chk("abort_iresps", 96'(iresps2),   96'h0);
        chk("abort_cnt",    96'(gcnt2),     96'h0);
        push_exp(0, 32'h6000, 0, -1, mem_data(32'h6000, 0));
        push_exp(1, 32'h5100, 3, 2, mem_data(32'h5100, 3));
        configure(0, 32'h6000, 4'd0, 1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        wait_done(100);
        chk("restart_cnt", 96'(gcnt2), 96'h0000_0001_0000_0001);

        // Wrap on the three-requester instance: ptr=2, requests on 0 and 1.
        ireqs3[1*79 +: 79] = pack_req(1'b1, 32'hA100, 4'd0);
        wait_busy3("wrap_first", 2'd1);
        finish3(1);
        ireqs3[0*79 +: 79] = pack_req(1'b1, 32'hA000, 4'd0);
        ireqs3[1*79 +: 79] = pack_req(1'b1, 32'hA110, 4'd0);
        wait_busy3("wrap_to_0", 2'd0);
        chk("wrap_oreq_addr", 96'(oreq3[73:42]), 96'h0000_A000);
        finish3(0);
        wait_busy3("wrap_then_1", 2'd1);
        finish3(1);
        @(negedge clk);
        chk("wrap_cnt", 96'(gcnt3), {32'd0, 32'd2, 32'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
